mem_bus_arbiter: RTL and testbench

- Shares the single processor-memory bus between the instruction cache (fetch loads) and the data cache (loads and stores).
- Routes one request per cycle to memory and returns the immediate response tag to the granted requester only.
- Tracks outstanding load tags so each completion (tag plus data) is steered back to the requester that issued it.
- Sits between icache/dcache controllers and the top-level proc2mem/mem2proc bus.

---
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single processor-memory bus between the instruction cache
// (fetch loads only) and the data cache (loads and stores). The arbiter
// grants one requester per cycle and forwards the memory's immediate
// response tag to that requester only. It also keeps an owner table of
// in-flight load tags, so each completion is steered back to the cache
// that issued the load.
//
// Ports
//   clock, reset            system clock, asynchronous active-low reset
//   Icache2arb_*            Icache request (BUS_LOAD only; anything else is idle)
//   Dcache2arb_*            Dcache request (BUS_LOAD / BUS_STORE) plus store data
//   arb2Icache_response/tag response tag and completion tag owned by Icache
//   arb2Dcache_response/tag response tag and completion tag owned by Dcache
//   arb2*_data              mem2proc_data passthrough, qualified by the tag port
//   proc2mem_*              granted command/address/data to memory
//   mem2proc_*              memory response tag, completion tag and data
//   outstanding_count       number of loads in flight
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Icache2arb_command,
  input  logic [63:0] Icache2arb_addr,
  input  logic [1:0]  Dcache2arb_command,
  input  logic [63:0] Dcache2arb_addr,
  input  logic [63:0] Dcache2arb_data,
  output logic [3:0]  arb2Icache_response,
  output logic [3:0]  arb2Icache_tag,
  output logic [63:0] arb2Icache_data,
  output logic [3:0]  arb2Dcache_response,
  output logic [3:0]  arb2Dcache_tag,
  output logic [63:0] arb2Dcache_data,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,
  output logic [3:0]  outstanding_count
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int         SW        = $clog2(STARVE_LIMIT + 1);

  // Owner table indexed by tag; entry 0 is never allocated because
  // tag 0 means "no tag" on both memory return paths.
  logic [15:0]   tag_valid;
  logic [15:0]   tag_owner;   // 0 = Icache, 1 = Dcache
  logic [SW-1:0] starve_cnt;

  logic          icache_req, dcache_req, dcache_is_load;
  logic          at_max, icache_elig, dcache_elig;
  logic          grant_icache, grant_dcache;
  logic          alloc, alloc_new, comp;
  logic [3:0]    count_next;
  logic [SW-1:0] starve_next;

  assign icache_req     = (Icache2arb_command == BUS_LOAD);
  assign dcache_is_load = (Dcache2arb_command == BUS_LOAD);
  assign dcache_req     = dcache_is_load || (Dcache2arb_command == BUS_STORE);
  assign at_max         = (outstanding_count == 4'(MAX_OUTSTANDING));
  assign icache_elig    = icache_req && !at_max;
  assign dcache_elig    = dcache_req && !(dcache_is_load && at_max);

  // Dcache has priority unless Icache has gone unanswered long enough.
  // Both grants are held off during reset so the bus stays idle.
  assign grant_icache = reset && icache_elig &&
                        ((starve_cnt == SW'(STARVE_LIMIT)) || !dcache_elig);
  assign grant_dcache = reset && dcache_elig && !grant_icache;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_icache) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = Icache2arb_addr;
    end else if (grant_dcache) begin
      proc2mem_command = Dcache2arb_command;
      proc2mem_addr    = Dcache2arb_addr;
      proc2mem_data    = Dcache2arb_data;
    end
  end

  assign arb2Icache_response = grant_icache ? mem2proc_response : 4'd0;
  assign arb2Dcache_response = grant_dcache ? mem2proc_response : 4'd0;

  // Completions for tags not in the table (e.g. issued before a reset)
  // are dropped silently.
  assign comp = reset && (mem2proc_tag != 4'd0) && tag_valid[mem2proc_tag];

  always_comb begin
    arb2Icache_tag = 4'd0;
    arb2Dcache_tag = 4'd0;
    if (comp) begin
      if (tag_owner[mem2proc_tag]) arb2Dcache_tag = mem2proc_tag;
      else                         arb2Icache_tag = mem2proc_tag;
    end
  end

  assign arb2Icache_data = mem2proc_data;
  assign arb2Dcache_data = mem2proc_data;

  // Only accepted loads are tracked; stores never complete with a tag.
  assign alloc = (grant_icache || (grant_dcache && dcache_is_load)) &&
                 (mem2proc_response != 4'd0);

  // An allocation adds to the count only if the entry is free once this
  // cycle's completion has been applied; overwriting a live entry does not.
  assign alloc_new = alloc && (!tag_valid[mem2proc_response] ||
                               (comp && (mem2proc_tag == mem2proc_response)));

  always_comb begin
    count_next = outstanding_count;
    if (alloc_new && !comp)      count_next = outstanding_count + 4'd1;
    else if (!alloc_new && comp) count_next = outstanding_count - 4'd1;
  end

  always_comb begin
    starve_next = '0;
    if (icache_req && (arb2Icache_response == 4'd0)) begin
      if (starve_cnt == SW'(STARVE_LIMIT)) starve_next = starve_cnt;
      else                                 starve_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_valid         <= '0;
      tag_owner         <= '0;
      starve_cnt        <= '0;
      outstanding_count <= '0;
    end else begin
      // Clear before set: a same-tag completion and reallocation leaves the
      // entry valid with the new owner.
      if (comp) tag_valid[mem2proc_tag] <= 1'b0;
      if (alloc) begin
        tag_valid[mem2proc_response] <= 1'b1;
        tag_owner[mem2proc_response] <= grant_dcache;
      end
      starve_cnt        <= starve_next;
      outstanding_count <= count_next;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic        clock, reset;
  logic [1:0]  Icache2arb_command, Dcache2arb_command;
  logic [63:0] Icache2arb_addr, Dcache2arb_addr, Dcache2arb_data;
  logic [3:0]  arb2Icache_response, arb2Icache_tag;
  logic [3:0]  arb2Dcache_response, arb2Dcache_tag;
  logic [63:0] arb2Icache_data, arb2Dcache_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  outstanding_count;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(15)) dut (
    .clock(clock), .reset(reset),
    .Icache2arb_command(Icache2arb_command), .Icache2arb_addr(Icache2arb_addr),
    .Dcache2arb_command(Dcache2arb_command), .Dcache2arb_addr(Dcache2arb_addr),
    .Dcache2arb_data(Dcache2arb_data),
    .arb2Icache_response(arb2Icache_response), .arb2Icache_tag(arb2Icache_tag),
    .arb2Icache_data(arb2Icache_data),
    .arb2Dcache_response(arb2Dcache_response), .arb2Dcache_tag(arb2Dcache_tag),
    .arb2Dcache_data(arb2Dcache_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data), .outstanding_count(outstanding_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: which tags are in flight and who owns them, and how
  // many cycles in a row Icache has asked without being answered.
  bit m_valid [16];
  bit m_owner [16];   // 1 = Dcache
  int m_starve;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 1; i < 16; i++) c += m_valid[i];
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_owner[i] = 0;
    end
    m_starve = 0;
  endtask

  // Drive one cycle's inputs, compare every output with the reference, then
  // advance the reference to what the coming clock edge should produce.
  task automatic bus_cycle(input logic [1:0] ic, input logic [63:0] ia,
                           input logic [1:0] dc, input logic [63:0] da,
                           input logic [63:0] dd, input logic [3:0] rsp,
                           input logic [3:0] tg, input logic [63:0] md);
    int cnt, win;
    bit i_ok, d_ok;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_data;
    logic [3:0]  e_ir, e_dr, e_it, e_dt;
    @(negedge clock);
    Icache2arb_command = ic; Icache2arb_addr = ia;
    Dcache2arb_command = dc; Dcache2arb_addr = da; Dcache2arb_data = dd;
    mem2proc_response = rsp; mem2proc_tag = tg; mem2proc_data = md;
    #1;
    cnt  = m_count();
    i_ok = (ic == BUS_LOAD) && (cnt < 15);
    d_ok = ((dc == BUS_LOAD) && (cnt < 15)) || (dc == BUS_STORE);
    if (i_ok && (m_starve >= 4 || !d_ok)) win = 1;
    else if (d_ok)                        win = 2;
    else                                  win = 0;
    e_cmd = BUS_NONE; e_addr = 0; e_data = 0;
    if (win == 1) begin e_cmd = BUS_LOAD; e_addr = ia; end
    if (win == 2) begin e_cmd = dc; e_addr = da; e_data = dd; end
    e_ir = (win == 1) ? rsp : 4'd0;
    e_dr = (win == 2) ? rsp : 4'd0;
    e_it = 0; e_dt = 0;
    if (tg != 0 && m_valid[tg]) begin
      if (m_owner[tg]) e_dt = tg;
      else             e_it = tg;
    end
    chk("cmd",   proc2mem_command,    e_cmd);
    chk("addr",  proc2mem_addr,       e_addr);
    chk("data",  proc2mem_data,       e_data);
    chk("i_rsp", arb2Icache_response, e_ir);
    chk("d_rsp", arb2Dcache_response, e_dr);
    chk("i_tag", arb2Icache_tag,      e_it);
    chk("d_tag", arb2Dcache_tag,      e_dt);
    chk("i_dat", arb2Icache_data,     md);
    chk("d_dat", arb2Dcache_data,     md);
    chk("count", outstanding_count,   cnt);
    if (tg != 0) m_valid[tg] = 0;
    if (rsp != 0 && (win == 1 || (win == 2 && dc == BUS_LOAD))) begin
      m_valid[rsp] = 1;
      m_owner[rsp] = (win == 2);
    end
    if (ic == BUS_LOAD && e_ir == 0) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
    else                             m_starve = 0;
  endtask

  // Asynchronous reset applied between edges, with requests present to show
  // that nothing leaks onto the bus or the response/tag ports while it is low.
  task automatic do_reset();
    @(negedge clock);
    #2;
    Icache2arb_command = BUS_LOAD;  Icache2arb_addr = 64'h300;
    Dcache2arb_command = BUS_STORE; Dcache2arb_addr = 64'h80; Dcache2arb_data = 64'h77;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd3; mem2proc_data = 64'h1;
    reset = 1'b0;
    #1;
    chk("rst_cmd",   proc2mem_command,    BUS_NONE);
    chk("rst_addr",  proc2mem_addr,       0);
    chk("rst_data",  proc2mem_data,       0);
    chk("rst_i_rsp", arb2Icache_response, 0);
    chk("rst_d_rsp", arb2Dcache_response, 0);
    chk("rst_i_tag", arb2Icache_tag,      0);
    chk("rst_d_tag", arb2Dcache_tag,      0);
    chk("rst_count", outstanding_count,   0);
    m_clear();
    @(negedge clock);
    #1 reset = 1'b1;
  endtask

  function automatic logic [3:0] pick_free();
    int s = $urandom_range(1, 15);
    for (int k = 0; k < 15; k++) begin
      int t = ((s - 1 + k) % 15) + 1;
      if (!m_valid[t]) return 4'(t);
    end
    return 4'd0;
  endfunction

  function automatic logic [3:0] pick_busy();
    int s = $urandom_range(1, 15);
    for (int k = 0; k < 15; k++) begin
      int t = ((s - 1 + k) % 15) + 1;
      if (m_valid[t]) return 4'(t);
    end
    return 4'd0;
  endfunction

  initial begin
    logic [3:0] rsp, tg;
    logic [1:0] ic, dc;
    m_clear();
    reset = 1'b0;
    Icache2arb_command = BUS_NONE; Icache2arb_addr = 0;
    Dcache2arb_command = BUS_NONE; Dcache2arb_addr = 0; Dcache2arb_data = 0;
    mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
    do_reset();

    // Single Icache load and its completion.
    bus_cycle(BUS_LOAD, 64'h100, BUS_NONE, 0, 0, 4'd3, 4'd0, 0);
    chk("tp1_cmd",   proc2mem_command,    BUS_LOAD);
    chk("tp1_i_rsp", arb2Icache_response, 4'd3);
    bus_cycle(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd3, 64'hDEAD);
    chk("tp1_i_tag", arb2Icache_tag,      4'd3);
    chk("tp1_count", outstanding_count,   4'd1);
    bus_cycle(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd0, 0);
    chk("tp1_count0", outstanding_count,  4'd0);

    // Dcache store wins four times, Icache forced through on the fifth.
    for (int i = 0; i < 4; i++) begin
      bus_cycle(BUS_LOAD, 64'h200, BUS_STORE, 64'h40, 64'h55, 4'd7, 4'd0, 0);
      chk("tp2_store", proc2mem_data, 64'h55);
    end
    bus_cycle(BUS_LOAD, 64'h200, BUS_STORE, 64'h40, 64'h55, 4'd4, 4'd0, 0);
    chk("tp2_starve_addr", proc2mem_addr,       64'h200);
    chk("tp2_starve_rsp",  arb2Icache_response, 4'd4);
    bus_cycle(BUS_LOAD, 64'h208, BUS_STORE, 64'h40, 64'h55, 4'd8, 4'd0, 0);
    chk("tp2_back_to_d",   proc2mem_command,    BUS_STORE);

    // Fill all 15 tags with Dcache loads, then probe the limit.
    do_reset();
    for (int t = 1; t <= 15; t++)
      bus_cycle(BUS_NONE, 0, BUS_LOAD, 64'(t * 8), 0, 4'(t), 4'd0, 0);
    bus_cycle(BUS_NONE, 0, BUS_LOAD, 64'h1000, 0, 4'd5, 4'd0, 0);
    chk("tp3_full_cmd", proc2mem_command,    BUS_NONE);
    chk("tp3_full_rsp", arb2Dcache_response, 4'd0);
    bus_cycle(BUS_NONE, 0, BUS_STORE, 64'h1000, 64'h99, 4'd5, 4'd0, 0);
    chk("tp3_store",    proc2mem_command,    BUS_STORE);
    chk("tp3_count",    outstanding_count,   4'd15);

    // Same-cycle completion and reallocation of tag 5.
    bus_cycle(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd6, 64'h6);
    bus_cycle(BUS_LOAD, 64'h500, BUS_NONE, 0, 0, 4'd5, 4'd5, 64'h5);
    chk("tp4_d_tag", arb2Dcache_tag, 4'd5);
    bus_cycle(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd5, 64'h55);
    chk("tp4_count",   outstanding_count, 4'd14);
    chk("tp4_new_own", arb2Icache_tag,    4'd5);

    // Completion of a tag that was never allocated.
    do_reset();
    bus_cycle(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd9, 64'h9);
    chk("tp5_i_tag", arb2Icache_tag, 4'd0);
    chk("tp5_d_tag", arb2Dcache_tag, 4'd0);

    // Reset with three loads in flight; later completion is dropped.
    for (int t = 1; t <= 3; t++)
      bus_cycle(BUS_LOAD, 64'(t * 16), BUS_NONE, 0, 0, 4'(t), 4'd0, 0);
    bus_cycle(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd0, 0);
    chk("tp6_pre", outstanding_count, 4'd3);
    do_reset();
    bus_cycle(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd2, 64'h2);
    chk("tp6_i_tag", arb2Icache_tag, 4'd0);

    // Randomised traffic, including occasional protocol violations
    // (allocation onto a live tag) and stray completions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      ic = 2'($urandom_range(0, 2));
      dc = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 7))
        0:       rsp = 4'd0;
        1:       rsp = 4'($urandom_range(1, 15));
        default: rsp = pick_free();
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2: tg = pick_busy();
        3:       tg = 4'($urandom_range(0, 15));
        default: tg = 4'd0;
      endcase
      bus_cycle(ic, {$urandom, $urandom}, dc, {$urandom, $urandom},
                {$urandom, $urandom}, rsp, tg, {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
